// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode map and the per-result flag bundle.
package alu_pkg;

  localparam logic [3:0] OP_SUB = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_DEC = 4'b0100;
  localparam logic [3:0] OP_INC = 4'b0101;
  localparam logic [3:0] OP_INV = 4'b0110;
  localparam logic [3:0] OP_LSL = 4'b1000;
  localparam logic [3:0] OP_LEQ = 4'b1001;
  localparam logic [3:0] OP_LSR = 4'b1010;
  localparam logic [3:0] OP_ASL = 4'b1100;
  localparam logic [3:0] OP_ASR = 4'b1110;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result and flags from operands and opcode.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_operation,
  output logic [WIDTH-1:0] o_s,
  output alu_flags_t       o_flags
);

  localparam logic [WIDTH-1:0] W_LIMIT = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] W_ONE   = WIDTH'(1);

  logic             w_big;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_sum, w_dif, w_inc, w_dec;
  logic [WIDTH-1:0] w_lsl, w_lsr, w_asr, w_asl_back;
  logic             w_leq;

  // Once b reaches WIDTH the low SHW bits no longer describe the shift, so w_big overrides them.
  assign w_big      = (i_b >= W_LIMIT);
  assign w_sh       = i_b[SHW-1:0];
  assign w_sum      = i_a + i_b;
  assign w_dif      = i_a - i_b;
  assign w_inc      = i_a + W_ONE;
  assign w_dec      = i_a - W_ONE;
  assign w_lsl      = i_a << w_sh;
  assign w_lsr      = i_a >> w_sh;
  assign w_asr      = WIDTH'($signed(i_a) >>> w_sh);
  assign w_asl_back = WIDTH'($signed(w_lsl) >>> w_sh);
  assign w_leq      = ($signed(i_a) <= $signed(i_b));

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_s              = '0;
    o_flags.overflow = 1'b0;
    o_flags.illegal  = 1'b0;
    unique case (i_operation)
      OP_SUB: begin
        o_s              = w_dif;
        o_flags.overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_dif[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_ADD: begin
        o_s              = w_sum;
        o_flags.overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_OR:  o_s = i_a | i_b;
      OP_AND: o_s = i_a & i_b;
      OP_DEC: begin
        o_s              = w_dec;
        o_flags.overflow = i_a[WIDTH-1] && !w_dec[WIDTH-1];
      end
      OP_INC: begin
        o_s              = w_inc;
        o_flags.overflow = !i_a[WIDTH-1] && w_inc[WIDTH-1];
      end
      OP_INV: o_s = ~i_a;
      OP_LSL: o_s = w_big ? '0 : w_lsl;
      OP_LEQ: o_s = {{(WIDTH-1){1'b0}}, w_leq};
      OP_LSR: o_s = w_big ? '0 : w_lsr;
      OP_ASL: begin
        // Shifting back arithmetically recovers a exactly iff no significant bit was lost.
        o_s              = w_big ? '0 : w_lsl;
        o_flags.overflow = w_big ? (|i_a) : (w_asl_back != i_a);
      end
      OP_ASR: o_s = w_big ? {WIDTH{i_a[WIDTH-1]}} : w_asr;
      default: o_flags.illegal = 1'b1;
    endcase
    o_flags.zero = (o_s == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake and full backpressure.
// Define ALU_PIPE_STICKY_OVF_EN to enable the ovf_sticky register and ovf_clr.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             overflow,
  output logic             zero,
  output logic             illegal,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_a, r_b;
  logic [3:0]       r_op;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_s;
  alu_flags_t       r_flags;

  logic             w_s2_adv;
  logic [WIDTH-1:0] w_s;
  alu_flags_t       w_flags;

  // in_ready depends only on registered state and out_ready, never on in_valid.
  assign w_s2_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;

  alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .i_a         (r_a),
    .i_b         (r_b),
    .i_operation (r_op),
    .o_s         (w_s),
    .o_flags     (w_flags)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (in_ready) r_s1_valid  <= in_valid;
      if (w_s2_adv) r_out_valid <= r_s1_valid;
    end
  end

  // NOTE: stage-1 operands carry no reset; they are only consumed while r_s1_valid is set.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      r_a  <= a;
      r_b  <= b;
      r_op <= operation;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s     <= '0;
      r_flags <= '0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_s     <= w_s;
      r_flags <= w_flags;
    end
  end

  assign out_valid = r_out_valid;
  assign S         = r_s;
  assign overflow  = r_flags.overflow;
  assign zero      = r_flags.zero;
  assign illegal   = r_flags.illegal;

`ifdef ALU_PIPE_STICKY_OVF_EN
  logic r_ovf_sticky;

  // A set on the same edge as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n)                                        r_ovf_sticky <= 1'b0;
    else if (r_out_valid && out_ready && r_flags.overflow) r_ovf_sticky <= 1'b1;
    else if (ovf_clr)                                  r_ovf_sticky <= 1'b0;
  end

  assign ovf_sticky = r_ovf_sticky;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = ovf_clr;
  assign ovf_sticky       = 1'b0;
`endif

endmodule
